// File: rtl/udp_pkg.sv
// Shared types and constants for the IPv4/UDP header parser.
package udp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IP_HDR  = 3'd1,
    S_IP_OPT  = 3'd2,
    S_UDP_HDR = 3'd3,
    S_PAYLOAD = 3'd4,
    S_SKIP    = 3'd5
  } state_t;

  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [3:0]  IPV4_IHL_MIN   = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  // 16-bit ones'-complement add with end-around carry.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ones_comp_sum16.sv
// Byte-serial 16-bit ones'-complement accumulator (big-endian word pairs).
// The sum output is look-ahead: it already includes the low byte presented
// this cycle, so the parent can judge a header on its final byte.
module ones_comp_sum16
  import udp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        clear,
  input  logic        valid,
  output logic [15:0] sum
);

  logic [15:0] acc;
  logic [7:0]  hi;
  logic        odd;

  // Combine the pending high byte with this cycle's low byte.
  always_comb begin
    sum = acc;
    if (clear)
      sum = 16'd0;
    else if (valid && odd)
      sum = ones_add16(acc, {hi, data});
  end

  // Collect high bytes and fold each completed word into the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 16'd0;
      hi  <= 8'd0;
      odd <= 1'b0;
    end else if (valid) begin
      if (clear || !odd) begin
        hi  <= data;
        odd <= 1'b1;
        if (clear)
          acc <= 16'd0;
      end else begin
        acc <= sum;
        odd <= 1'b0;
      end
    end else if (clear) begin
      acc <= 16'd0;
      odd <= 1'b0;
    end
  end

endmodule

// File: rtl/ipv4_udp_parse.sv
// IPv4 + UDP header parser: validates the IP header, extracts addresses and
// ports, and forwards exactly udp_len-8 payload bytes.
//
// state     | meaning
// S_IDLE    | waiting for ip_start
// S_IP_HDR  | IP header bytes 1..19
// S_IP_OPT  | IP option bytes 20..IHL*4-1
// S_UDP_HDR | UDP header bytes 0..7
// S_PAYLOAD | forwarding UDP payload
// S_SKIP    | frame rejected or not UDP, ignore until ip_start
module ipv4_udp_parse
  import udp_pkg::*;
#(
  parameter int CHECK_CSUM = 1
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic [7:0]  eth_byte,
  input  logic        input_ready,
  input  logic        ip_start,
  output logic        valid_udp,
  output logic        hdr_err,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_len,
  output logic [7:0]  payload_byte,
  output logic        payload_valid,
  output logic        payload_last
);

  state_t      state;
  logic [5:0]  cnt;
  logic [3:0]  ihl;
  logic        frag_bad;
  logic        proto_udp;
  logic [15:0] remaining;

  logic        csum_clear;
  logic        csum_valid;
  logic [15:0] csum_sum;
  logic [5:0]  hdr_last_idx;
  logic        hdr_done;
  logic        hdr_bad;

  // Feed every IP header byte, starting fresh on the ip_start byte.
  always_comb begin
    csum_clear = input_ready && ip_start;
    csum_valid = input_ready && (ip_start || state == S_IP_HDR || state == S_IP_OPT);
  end

  ones_comp_sum16 u_csum (
    .clk   (main_clk),
    .rst_n (main_rst_n),
    .data  (eth_byte),
    .clear (csum_clear),
    .valid (csum_valid),
    .sum   (csum_sum)
  );

  // Detect the final IP header byte and judge the header on it.
  always_comb begin
    hdr_last_idx = {ihl, 2'b00} - 6'd1;
    hdr_done     = input_ready && !ip_start &&
                   ((state == S_IP_HDR && cnt == 6'd19 && ihl == IPV4_IHL_MIN) ||
                    (state == S_IP_OPT && cnt == hdr_last_idx));
    hdr_bad      = frag_bad || ((CHECK_CSUM != 0) && (csum_sum != 16'hFFFF));
  end

  // Main parse FSM, field capture and payload forwarding.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state         <= S_IDLE;
      cnt           <= 6'd0;
      ihl           <= 4'd0;
      frag_bad      <= 1'b0;
      proto_udp     <= 1'b0;
      remaining     <= 16'd0;
      valid_udp     <= 1'b0;
      hdr_err       <= 1'b0;
      src_ip        <= 32'd0;
      dst_ip        <= 32'd0;
      src_port      <= 16'd0;
      dst_port      <= 16'd0;
      udp_len       <= 16'd0;
      payload_byte  <= 8'd0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
    end else begin
      valid_udp     <= 1'b0;
      hdr_err       <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      if (input_ready) begin
        if (ip_start) begin
          cnt       <= 6'd1;
          ihl       <= eth_byte[3:0];
          frag_bad  <= 1'b0;
          proto_udp <= 1'b0;
          if (eth_byte[7:4] != IPV4_VERSION || eth_byte[3:0] < IPV4_IHL_MIN) begin
            state   <= S_SKIP;
            hdr_err <= 1'b1;
          end else begin
            state   <= S_IP_HDR;
          end
        end else begin
          case (state)
            S_IP_HDR, S_IP_OPT: begin
              cnt <= cnt + 6'd1;
              if (state == S_IP_HDR) begin
                if (cnt == 6'd6)
                  frag_bad <= eth_byte[5] | (|eth_byte[4:0]);
                if (cnt == 6'd7)
                  frag_bad <= frag_bad | (|eth_byte);
                if (cnt == 6'd9)
                  proto_udp <= (eth_byte == IP_PROTO_UDP);
                if (cnt >= 6'd12 && cnt <= 6'd15)
                  src_ip <= {src_ip[23:0], eth_byte};
                if (cnt >= 6'd16 && cnt <= 6'd19)
                  dst_ip <= {dst_ip[23:0], eth_byte};
                if (cnt == 6'd19 && ihl != IPV4_IHL_MIN)
                  state <= S_IP_OPT;
              end
              if (hdr_done) begin
                cnt <= 6'd0;
                if (hdr_bad) begin
                  state   <= S_SKIP;
                  hdr_err <= 1'b1;
                end else if (!proto_udp) begin
                  state   <= S_SKIP;
                end else begin
                  state   <= S_UDP_HDR;
                end
              end
            end
            S_UDP_HDR: begin
              cnt <= cnt + 6'd1;
              if (cnt == 6'd0 || cnt == 6'd1)
                src_port <= {src_port[7:0], eth_byte};
              if (cnt == 6'd2 || cnt == 6'd3)
                dst_port <= {dst_port[7:0], eth_byte};
              if (cnt == 6'd4 || cnt == 6'd5)
                udp_len <= {udp_len[7:0], eth_byte};
              if (cnt == 6'd7) begin
                cnt <= 6'd0;
                if (udp_len < UDP_HDR_BYTES) begin
                  state   <= S_SKIP;
                  hdr_err <= 1'b1;
                end else begin
                  valid_udp <= 1'b1;
                  remaining <= udp_len - UDP_HDR_BYTES;
                  state     <= (udp_len == UDP_HDR_BYTES) ? S_IDLE : S_PAYLOAD;
                end
              end
            end
            S_PAYLOAD: begin
              payload_byte  <= eth_byte;
              payload_valid <= 1'b1;
              remaining     <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                payload_last <= 1'b1;
                state        <= S_IDLE;
              end
            end
            S_IDLE, S_SKIP: ;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_udp_parse.sv
// Scoreboard bench for ipv4_udp_parse: two instances (checksum enforced and
// ignored) share one byte stream; a frame-level reference model predicts the
// output events of each, and a negedge monitor pops and compares them.
module tb_ipv4_udp_parse;

  localparam int EV_VALID = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_PAY   = 2;

  typedef struct {
    int          kind;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
    logic [7:0]  pb;
    logic        last;
  } evt_t;

  logic        main_clk = 1'b0;
  logic        main_rst_n;
  logic [7:0]  eth_byte;
  logic        input_ready;
  logic        ip_start;

  logic        a_valid_udp, a_hdr_err, a_payload_valid, a_payload_last;
  logic [31:0] a_src_ip, a_dst_ip;
  logic [15:0] a_src_port, a_dst_port, a_udp_len;
  logic [7:0]  a_payload_byte;
  logic        b_valid_udp, b_hdr_err, b_payload_valid, b_payload_last;
  logic [31:0] b_src_ip, b_dst_ip;
  logic [15:0] b_src_port, b_dst_port, b_udp_len;
  logic [7:0]  b_payload_byte;

  int   n_cmp = 0;
  int   n_fail = 0;
  evt_t qa[$];
  evt_t qb[$];
  logic [7:0] frm[$];
  logic [7:0] pay[$];

  always #5 main_clk = ~main_clk;

  ipv4_udp_parse #(.CHECK_CSUM(1)) dut_a (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .eth_byte(eth_byte),
    .input_ready(input_ready), .ip_start(ip_start),
    .valid_udp(a_valid_udp), .hdr_err(a_hdr_err),
    .src_ip(a_src_ip), .dst_ip(a_dst_ip),
    .src_port(a_src_port), .dst_port(a_dst_port), .udp_len(a_udp_len),
    .payload_byte(a_payload_byte), .payload_valid(a_payload_valid),
    .payload_last(a_payload_last)
  );

  ipv4_udp_parse #(.CHECK_CSUM(0)) dut_b (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .eth_byte(eth_byte),
    .input_ready(input_ready), .ip_start(ip_start),
    .valid_udp(b_valid_udp), .hdr_err(b_hdr_err),
    .src_ip(b_src_ip), .dst_ip(b_dst_ip),
    .src_port(b_src_port), .dst_port(b_dst_port), .udp_len(b_udp_len),
    .payload_byte(b_payload_byte), .payload_valid(b_payload_valid),
    .payload_last(b_payload_last)
  );

  function automatic evt_t mk_evt(input int kind);
    evt_t e;
    e.kind = kind; e.sip = '0; e.dip = '0; e.sp = '0; e.dp = '0;
    e.len = '0; e.pb = '0; e.last = 1'b0;
    return e;
  endfunction

  // Build an IPv4/UDP packet (plus trailing padding) into frm from pay.
  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                       input bit mf, input logic [12:0] frag, input bit flip,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp,
                       input int len_ovr, input int npad);
    int hl;
    int unsigned s;
    logic [15:0] tl;
    logic [15:0] ulen;
    logic [15:0] cs;
    hl   = (ihl < 5) ? 20 : int'(ihl) * 4;
    ulen = (len_ovr >= 0) ? 16'(len_ovr) : 16'(8 + pay.size());
    tl   = 16'(hl + 8 + pay.size());
    frm.delete();
    frm.push_back({ver, ihl}); frm.push_back(8'h00);
    frm.push_back(tl[15:8]);   frm.push_back(tl[7:0]);
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    frm.push_back({2'b00, mf, frag[12:8]}); frm.push_back(frag[7:0]);
    frm.push_back(8'h40); frm.push_back(proto);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    while (frm.size() < hl) frm.push_back(8'($urandom));
    s = 0;
    for (int i = 0; i < hl; i += 2) s += {frm[i], frm[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    frm[10] = cs[15:8];
    frm[11] = cs[7:0];
    if (flip) frm[10] = frm[10] ^ 8'hFF;
    frm.push_back(sp[15:8]);   frm.push_back(sp[7:0]);
    frm.push_back(dp[15:8]);   frm.push_back(dp[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00);      frm.push_back(8'h00);
    foreach (pay[i]) frm.push_back(pay[i]);
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
  endtask

  // Reference model: the events each instance should emit when only the
  // first n bytes of frm are delivered before the next ip_start.
  task automatic predict(input int n);
    int hl;
    int unsigned s;
    bit csum_ok, frag_bad;
    logic [15:0] len;
    int rem;
    evt_t e;
    if (frm[0][7:4] != 4'd4 || frm[0][3:0] < 4'd5) begin
      if (n >= 1) begin qa.push_back(mk_evt(EV_ERR)); qb.push_back(mk_evt(EV_ERR)); end
      return;
    end
    hl = int'(frm[0][3:0]) * 4;
    if (n < hl) return;
    s = 0;
    for (int i = 0; i < hl; i += 2) s += {frm[i], frm[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    csum_ok  = (s == 32'hFFFF);
    frag_bad = frm[6][5] || ({frm[6][4:0], frm[7]} != 13'd0);
    for (int w = 0; w < 2; w++) begin
      if (((w == 0) && !csum_ok) || frag_bad) begin
        if (w == 0) qa.push_back(mk_evt(EV_ERR)); else qb.push_back(mk_evt(EV_ERR));
        continue;
      end
      if (frm[9] != 8'd17 || n < hl + 8) continue;
      len = {frm[hl+4], frm[hl+5]};
      if (len < 16'd8) begin
        if (w == 0) qa.push_back(mk_evt(EV_ERR)); else qb.push_back(mk_evt(EV_ERR));
        continue;
      end
      e = mk_evt(EV_VALID);
      e.sip = {frm[12], frm[13], frm[14], frm[15]};
      e.dip = {frm[16], frm[17], frm[18], frm[19]};
      e.sp  = {frm[hl], frm[hl+1]};
      e.dp  = {frm[hl+2], frm[hl+3]};
      e.len = len;
      if (w == 0) qa.push_back(e); else qb.push_back(e);
      rem = int'(len) - 8;
      for (int i = 0; i < rem && hl + 8 + i < n; i++) begin
        e = mk_evt(EV_PAY);
        e.pb   = frm[hl+8+i];
        e.last = (i == rem - 1);
        if (w == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic rdy, input logic st, input logic [7:0] b);
    input_ready = rdy;
    ip_start    = st;
    eth_byte    = b;
    @(posedge main_clk);
    #1;
  endtask

  // mode 0: gap-free, 1: input_ready every other cycle, 2: random gaps.
  task automatic send(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1)
        drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (mode == 2 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      drive(1'b1, (i == 0), frm[i]);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input int n, input int mode);
    predict(n);
    send(n, mode);
  endtask

  task automatic check_evt(input int w, input evt_t got);
    evt_t e;
    bit   ok;
    n_cmp++;
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind=%0d pb=%h last=%0d, required no event", w, got.kind, got.pb, got.last);
      return;
    end
    if (w == 0) e = qa.pop_front(); else e = qb.pop_front();
    ok = (got.kind == e.kind);
    if (ok && e.kind == EV_VALID)
      ok = got.sip == e.sip && got.dip == e.dip && got.sp == e.sp && got.dp == e.dp && got.len == e.len;
    if (ok && e.kind == EV_PAY)
      ok = got.pb == e.pb && got.last == e.last;
    if (!ok) begin
      n_fail++;
      $display("FAIL event dut%0d: got kind=%0d sip=%h dip=%h sp=%h dp=%h len=%h pb=%h last=%0d, required kind=%0d sip=%h dip=%h sp=%h dp=%h len=%h pb=%h last=%0d",
               w, got.kind, got.sip, got.dip, got.sp, got.dp, got.len, got.pb, got.last,
               e.kind, e.sip, e.dip, e.sp, e.dp, e.len, e.pb, e.last);
    end
  endtask

  task automatic observe(input int w, input logic vu, input logic he, input logic pv, input logic pl,
                         input logic [7:0] pb, input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ln);
    evt_t g;
    if (vu) begin
      g = mk_evt(EV_VALID); g.sip = sip; g.dip = dip; g.sp = sp; g.dp = dp; g.len = ln;
      check_evt(w, g);
    end
    if (he) check_evt(w, mk_evt(EV_ERR));
    if (pv) begin
      g = mk_evt(EV_PAY); g.pb = pb; g.last = pl;
      check_evt(w, g);
    end
    if (pl && !pv) begin
      n_cmp++; n_fail++;
      $display("FAIL last_without_valid dut%0d: got payload_last=1 payload_valid=0, required payload_last=0", w);
    end
  endtask

  // Monitor: sample both instances mid-cycle.
  always @(negedge main_clk) begin
    if (main_rst_n) begin
      observe(0, a_valid_udp, a_hdr_err, a_payload_valid, a_payload_last, a_payload_byte,
              a_src_ip, a_dst_ip, a_src_port, a_dst_port, a_udp_len);
      observe(1, b_valid_udp, b_hdr_err, b_payload_valid, b_payload_last, b_payload_byte,
              b_src_ip, b_dst_ip, b_src_port, b_dst_port, b_udp_len);
    end
  end

  task automatic check_zero(input string tag);
    logic [167:0] va, vb;
    va = {a_valid_udp, a_hdr_err, a_payload_valid, a_payload_last, a_payload_byte,
          a_src_ip, a_dst_ip, a_src_port, a_dst_port, a_udp_len, 28'd0};
    vb = {b_valid_udp, b_hdr_err, b_payload_valid, b_payload_last, b_payload_byte,
          b_src_ip, b_dst_ip, b_src_port, b_dst_port, b_udp_len, 28'd0};
    n_cmp++;
    if (va != '0) begin n_fail++; $display("FAIL %s dut0: got outputs=%h, required all zero", tag, va); end
    n_cmp++;
    if (vb != '0) begin n_fail++; $display("FAIL %s dut1: got outputs=%h, required all zero", tag, vb); end
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 200 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge main_clk);
    #1;
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got pending expected events dut0=%0d dut1=%0d, required 0", tag, qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic basic_payload();
    pay.delete();
    pay.push_back(8'hDE); pay.push_back(8'hAD); pay.push_back(8'hBE); pay.push_back(8'hEF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    main_rst_n = 1'b0; input_ready = 1'b0; ip_start = 1'b0; eth_byte = 8'h00;
    repeat (3) @(posedge main_clk);
    #1;
    check_zero("reset_state");
    main_rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    // Reference frame, good checksum, 4 padding bytes.
    basic_payload();
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 4);
    frame(frm.size(), 0);

    // Corrupted checksum: rejected when enforced, accepted when ignored.
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b1, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 4);
    frame(frm.size(), 0);

    // TCP frame is skipped silently, then a UDP frame parses normally.
    build(4'd4, 4'd5, 8'd6, 1'b0, 13'd0, 1'b0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 0);
    frame(frm.size(), 0);
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'hC0A80101, 32'hC0A80102, 16'h0400, 16'h0035, -1, 2);
    frame(frm.size(), 0);

    // IHL=6 with one option word.
    basic_payload();
    build(4'd4, 4'd6, 8'd17, 1'b0, 13'd0, 1'b0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 0);
    frame(frm.size(), 0);

    // Zero-length payload, then udp_len below the header size.
    pay.delete();
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h01020304, 32'h05060708, 16'hAAAA, 16'hBBBB, -1, 3);
    frame(frm.size(), 0);
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h01020304, 32'h05060708, 16'hAAAA, 16'hBBBB, 7, 3);
    frame(frm.size(), 0);

    // Toggled input_ready and ip_start mid-payload.
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h0A000003, 32'h0A000004, 16'h1111, 16'h2222, -1, 0);
    frame(20 + 8 + 4, 1);
    basic_payload();
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 4);
    frame(frm.size(), 1);
    wait_drain("drain_before_reset");

    // Reset pulse in the middle of the UDP header.
    basic_payload();
    build(4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 1'b0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, -1, 0);
    frame(20 + 3, 0);
    #3;
    main_rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge main_clk);
    #1;
    main_rst_n = 1'b1;
    frame(frm.size(), 0);

    // Randomized frames with assorted defects, gaps and truncation.
    for (int f = 0; f < 60; f++) begin
      logic [3:0] ver, ihl;
      logic [7:0] proto;
      bit mf, flip;
      logic [12:0] frag;
      int len_ovr, n;
      ver = 4'd4; ihl = 4'(5 + $urandom_range(0, 3)); proto = 8'd17;
      mf = 1'b0; frag = 13'd0; flip = 1'b0; len_ovr = -1;
      case ($urandom_range(0, 11))
        0: ver = 4'd6;
        1: ihl = 4'($urandom_range(0, 4));
        2: proto = 8'd6;
        3: mf = 1'b1;
        4: frag = 13'($urandom_range(1, 8191));
        5: flip = 1'b1;
        6: len_ovr = $urandom_range(0, 7);
        default: ;
      endcase
      pay.delete();
      repeat ($urandom_range(0, 16)) pay.push_back(8'($urandom));
      build(ver, ihl, proto, mf, frag, flip, $urandom, $urandom, 16'($urandom), 16'($urandom),
            len_ovr, $urandom_range(0, 4));
      n = frm.size();
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, frm.size());
      frame(n, $urandom_range(0, 2));
    end

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    wait_drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
